vx_mem_responder: RTL and testbench

VX_MEM_RESPONDER -- requirements
Module: VX_mem_responder

---
 rtl/vx_mem_responder.sv | 155 +++++++++++++++
 tb/tb_vx_mem_responder.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/vx_mem_responder.sv
// Byte-enabled word memory answering reads in order after a fixed latency.
// Reads flow through a shift pipeline into a response FIFO; credits bound how many may be in flight.
module vx_mem_responder #(
  parameter int DATA_WIDTH    = 64,
  parameter int ADDR_WIDTH    = 26,
  parameter int TAG_WIDTH     = 8,
  parameter int MEM_ADDR_BITS = 10,
  parameter int LATENCY       = 4,
  parameter int QUEUE_DEPTH   = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    mem_req_valid,
  input  logic                    mem_req_rw,
  input  logic [DATA_WIDTH/8-1:0] mem_req_byteen,
  input  logic [ADDR_WIDTH-1:0]   mem_req_addr,
  input  logic [DATA_WIDTH-1:0]   mem_req_data,
  input  logic [TAG_WIDTH-1:0]    mem_req_tag,
  output logic                    mem_req_ready,
  output logic                    mem_rsp_valid,
  output logic [DATA_WIDTH-1:0]   mem_rsp_data,
  output logic [TAG_WIDTH-1:0]    mem_rsp_tag,
  input  logic                    mem_rsp_ready,
  output logic                    busy
);

  localparam int BYTES = DATA_WIDTH / 8;
  localparam int DEPTH = 1 << MEM_ADDR_BITS;
  localparam int CNT_W = $clog2(QUEUE_DEPTH + 1);
  localparam int PTR_W = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
  localparam int PD_W  = LATENCY * DATA_WIDTH;
  localparam int PT_W  = LATENCY * TAG_WIDTH;
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(QUEUE_DEPTH);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(QUEUE_DEPTH - 1);

  logic [DATA_WIDTH-1:0]    mem [DEPTH];
  logic [MEM_ADDR_BITS-1:0] idx;
  logic [DATA_WIDTH-1:0]    wr_word;
  logic [DATA_WIDTH-1:0]    rd_word;

  logic [CNT_W-1:0] outstanding;
  logic             req_fire, rd_fire, wr_fire, rsp_fire;

  logic [LATENCY-1:0] pipe_valid;
  logic [PD_W-1:0]    pipe_data;
  logic [PT_W-1:0]    pipe_tag;
  logic                  out_valid;
  logic [DATA_WIDTH-1:0] out_data;
  logic [TAG_WIDTH-1:0]  out_tag;

  logic [DATA_WIDTH-1:0] fifo_data [QUEUE_DEPTH];
  logic [TAG_WIDTH-1:0]  fifo_tag  [QUEUE_DEPTH];
  logic [PTR_W-1:0]      wr_ptr, rd_ptr;
  logic [CNT_W-1:0]      fifo_count;
  logic                  fifo_empty, fifo_full, fifo_push, fifo_pop;

  logic unused_addr;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_LAST) ? '0 : p + 1'b1;
  endfunction

  // Upper address bits alias onto the same storage.
  assign idx         = mem_req_addr[MEM_ADDR_BITS-1:0];
  assign unused_addr = ^mem_req_addr;

  assign mem_req_ready = outstanding < CNT_MAX;
  assign req_fire      = mem_req_valid && mem_req_ready;
  assign rd_fire       = req_fire && !mem_req_rw;
  assign wr_fire       = req_fire && mem_req_rw;
  assign busy          = outstanding != '0;
  assign rd_word       = mem[idx];

  always_comb begin
    wr_word = mem[idx];
    for (int b = 0; b < BYTES; b++) begin
      if (mem_req_byteen[b]) wr_word[b*8 +: 8] = mem_req_data[b*8 +: 8];
    end
  end

  always_ff @(posedge clk) begin
    if (reset && wr_fire) mem[idx] <= wr_word;
  end

  // Stage 0 sits in the low slice; the oldest read leaves from the top slice.
  always_ff @(posedge clk) begin
    if (!reset) pipe_valid <= '0;
    else        pipe_valid <= LATENCY'({pipe_valid, rd_fire});
  end

  always_ff @(posedge clk) begin
    pipe_data <= PD_W'({pipe_data, rd_word});
    pipe_tag  <= PT_W'({pipe_tag, mem_req_tag});
  end

  assign out_valid = pipe_valid[LATENCY-1];
  assign out_data  = pipe_data[(LATENCY-1)*DATA_WIDTH +: DATA_WIDTH];
  assign out_tag   = pipe_tag[(LATENCY-1)*TAG_WIDTH +: TAG_WIDTH];

  // An empty FIFO is bypassed, so a pipeline output taken immediately never occupies a slot.
  assign fifo_empty = fifo_count == '0;
  assign fifo_full  = fifo_count == CNT_MAX;
  assign fifo_push  = out_valid && !(fifo_empty && mem_rsp_ready);
  assign fifo_pop   = !fifo_empty && mem_rsp_ready;

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      assert (!(fifo_push && fifo_full && !fifo_pop));
      if (fifo_push) wr_ptr <= ptr_inc(wr_ptr);
      if (fifo_pop)  rd_ptr <= ptr_inc(rd_ptr);
      case ({fifo_push, fifo_pop})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (fifo_push) begin
      fifo_data[wr_ptr] <= out_data;
      fifo_tag[wr_ptr]  <= out_tag;
    end
  end

  always_comb begin
    mem_rsp_valid = out_valid;
    mem_rsp_data  = out_data;
    mem_rsp_tag   = out_tag;
    if (!fifo_empty) begin
      mem_rsp_valid = 1'b1;
      mem_rsp_data  = fifo_data[rd_ptr];
      mem_rsp_tag   = fifo_tag[rd_ptr];
    end
  end

  assign rsp_fire = mem_rsp_valid && mem_rsp_ready;

  always_ff @(posedge clk) begin
    if (!reset) begin
      outstanding <= '0;
    end else begin
      case ({rd_fire, rsp_fire})
        2'b10:   outstanding <= outstanding + 1'b1;
        2'b01:   outstanding <= outstanding - 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_vx_mem_responder.sv
// Directed bench for vx_mem_responder: a byte-merging memory model feeds a response scoreboard,
// plus cycle-exact checks of latency, credit back-pressure, aliasing and mid-flight reset.
module tb_vx_mem_responder;

  logic        clk = 1'b0;
  logic        reset;
  logic        mem_req_valid;
  logic        mem_req_rw;
  logic [7:0]  mem_req_byteen;
  logic [25:0] mem_req_addr;
  logic [63:0] mem_req_data;
  logic [7:0]  mem_req_tag;
  logic        mem_req_ready;
  logic        mem_rsp_valid;
  logic [63:0] mem_rsp_data;
  logic [7:0]  mem_rsp_tag;
  logic        mem_rsp_ready;
  logic        busy;

  typedef struct {
    logic [7:0]  tag;
    logic [63:0] data;
  } exp_t;

  exp_t        sb[$];
  logic [63:0] model_mem [1024];
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  vx_mem_responder dut (
    .clk            (clk),
    .reset          (reset),
    .mem_req_valid  (mem_req_valid),
    .mem_req_rw     (mem_req_rw),
    .mem_req_byteen (mem_req_byteen),
    .mem_req_addr   (mem_req_addr),
    .mem_req_data   (mem_req_data),
    .mem_req_tag    (mem_req_tag),
    .mem_req_ready  (mem_req_ready),
    .mem_rsp_valid  (mem_rsp_valid),
    .mem_rsp_data   (mem_rsp_data),
    .mem_rsp_tag    (mem_rsp_tag),
    .mem_rsp_ready  (mem_rsp_ready),
    .busy           (busy)
  );

  task automatic checkOutput(input string name, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", name, observed, expected);
    end
  endtask

  // Responses are scored at the falling edge; inputs change and state is checked 1 after the rising edge.
  task automatic nextCycle();
    exp_t e;
    @(negedge clk);
    if (mem_rsp_valid === 1'b1 && mem_rsp_ready === 1'b1) begin
      if (sb.size() == 0) begin
        checkOutput("unexpected_rsp", mem_rsp_valid, 64'd0);
      end else begin
        e = sb.pop_front();
        checkOutput("sb_rsp_tag", mem_rsp_tag, e.tag);
        checkOutput("sb_rsp_data", mem_rsp_data, e.data);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic rw, input logic [25:0] addr, input logic [63:0] data,
                               input logic [7:0] be, input logic [7:0] t, input bit track);
    bit   accepted = 0;
    exp_t e;
    mem_req_valid  = 1'b1;
    mem_req_rw     = rw;
    mem_req_addr   = addr;
    mem_req_data   = data;
    mem_req_byteen = be;
    mem_req_tag    = t;
    for (int i = 0; i < 32 && !accepted; i++) begin
      if (mem_req_ready === 1'b1) begin
        accepted = 1;
        if (rw) begin
          for (int b = 0; b < 8; b++)
            if (be[b]) model_mem[addr[9:0]][b*8 +: 8] = data[b*8 +: 8];
        end else if (track) begin
          e.tag  = t;
          e.data = model_mem[addr[9:0]];
          sb.push_back(e);
        end
      end
      nextCycle();
    end
    mem_req_valid = 1'b0;
    if (!accepted) checkOutput("req_accept_timeout", mem_req_ready, 64'd1);
  endtask

  // Single read with nothing else outstanding: response must appear exactly 4 cycles after accept.
  task automatic readCheckLatency(input logic [25:0] addr, input logic [7:0] t, input logic [63:0] exp_data);
    applyStimulus(1'b0, addr, 64'd0, 8'h00, t, 1'b1);
    checkOutput("busy_inflight", busy, 64'd1);
    nextCycle();
    nextCycle();
    checkOutput("rsp_not_early", mem_rsp_valid, 64'd0);
    nextCycle();
    checkOutput("rsp_valid_at_latency", mem_rsp_valid, 64'd1);
    checkOutput("rsp_tag_at_latency", mem_rsp_tag, t);
    checkOutput("rsp_data_at_latency", mem_rsp_data, exp_data);
    nextCycle();
  endtask

  task automatic waitDrain();
    for (int i = 0; i < 64 && (sb.size() != 0 || busy !== 1'b0); i++) nextCycle();
    checkOutput("drain_sb_empty", sb.size(), 64'd0);
    checkOutput("drain_busy", busy, 64'd0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    exp_t e;
    reset          = 1'b0;
    mem_req_valid  = 1'b0;
    mem_req_rw     = 1'b0;
    mem_req_byteen = '0;
    mem_req_addr   = '0;
    mem_req_data   = '0;
    mem_req_tag    = '0;
    mem_rsp_ready  = 1'b1;

    repeat (2) nextCycle();
    checkOutput("reset_rsp_valid", mem_rsp_valid, 64'd0);
    checkOutput("reset_busy", busy, 64'd0);
    checkOutput("reset_req_ready", mem_req_ready, 64'd1);
    reset = 1'b1;
    nextCycle();

    // Full write then read with exact latency.
    applyStimulus(1'b1, 26'd5, 64'h1122334455667788, 8'hFF, 8'h00, 1'b0);
    readCheckLatency(26'd5, 8'h3A, 64'h1122334455667788);
    waitDrain();

    // Partial write merges only the low four bytes.
    applyStimulus(1'b1, 26'd5, 64'hAAAAAAAA_BBBBBBBB, 8'h0F, 8'h00, 1'b0);
    readCheckLatency(26'd5, 8'h3B, 64'h11223344BBBBBBBB);
    waitDrain();

    // Write with no byte enables leaves the word alone.
    applyStimulus(1'b1, 26'd5, 64'hDEADBEEF_CAFEF00D, 8'h00, 8'h00, 1'b0);
    readCheckLatency(26'd5, 8'h3C, 64'h11223344BBBBBBBB);
    waitDrain();

    // Address 5+1024 aliases onto address 5.
    readCheckLatency(26'd1029, 8'h3D, 64'h11223344BBBBBBBB);
    waitDrain();

    // Credit exhaustion with a stalled consumer.
    for (int i = 0; i < 4; i++)
      applyStimulus(1'b1, 26'(10 + i), 64'(64'h0101010101010101 * (i + 1)), 8'hFF, 8'h00, 1'b0);
    mem_rsp_ready = 1'b0;
    for (int i = 0; i < 4; i++)
      applyStimulus(1'b0, 26'(10 + i), 64'd0, 8'h00, 8'(8'h50 + i), 1'b1);
    checkOutput("ready_low_after_4th", mem_req_ready, 64'd0);
    mem_req_valid = 1'b1;
    mem_req_rw    = 1'b0;
    mem_req_addr  = 26'd13;
    mem_req_tag   = 8'h54;
    for (int i = 0; i < 6; i++) begin
      nextCycle();
      checkOutput("ready_low_stalled", mem_req_ready, 64'd0);
    end
    checkOutput("stall_valid", mem_rsp_valid, 64'd1);
    checkOutput("stall_tag", mem_rsp_tag, 64'h50);
    checkOutput("stall_data", mem_rsp_data, model_mem[10]);
    nextCycle();
    checkOutput("stall_tag_stable", mem_rsp_tag, 64'h50);
    checkOutput("stall_data_stable", mem_rsp_data, model_mem[10]);

    // One-cycle consume while the fifth read waits: freed credit shows a cycle later.
    mem_rsp_ready = 1'b1;
    checkOutput("ready_low_in_fire_cycle", mem_req_ready, 64'd0);
    nextCycle();
    mem_rsp_ready = 1'b0;
    checkOutput("ready_high_after_fire", mem_req_ready, 64'd1);
    e.tag  = 8'h54;
    e.data = model_mem[13];
    sb.push_back(e);
    nextCycle();
    mem_req_valid = 1'b0;
    checkOutput("ready_low_refilled", mem_req_ready, 64'd0);
    checkOutput("busy_refilled", busy, 64'd1);
    mem_rsp_ready = 1'b1;
    waitDrain();

    // Reset with three reads in flight: they vanish, storage survives.
    for (int i = 0; i < 3; i++)
      applyStimulus(1'b0, 26'd5, 64'd0, 8'h00, 8'(8'h60 + i), 1'b0);
    reset = 1'b0;
    nextCycle();
    checkOutput("midreset_rsp_valid", mem_rsp_valid, 64'd0);
    checkOutput("midreset_busy", busy, 64'd0);
    checkOutput("midreset_req_ready", mem_req_ready, 64'd1);
    reset = 1'b1;
    for (int i = 0; i < 8; i++) begin
      nextCycle();
      checkOutput("no_rsp_after_reset", mem_rsp_valid, 64'd0);
    end
    readCheckLatency(26'd5, 8'h63, 64'h11223344BBBBBBBB);
    waitDrain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
